// File: rtl/ps2_bram_arbiter.sv
// ps2_bram_arbiter
// Shares one single-port BRAM between CPU bus strobes and a PS2 scan-code
// ring buffer. Fixed priority: CPU write > CPU read > pending device write.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_cpu_we/re/addr/wdata CPU single-cycle access strobes
//   o_cpu_rdata/rvalid    CPU read data, valid 2 cycles after i_cpu_re
//   i_cpu_pop, i_cpu_clr_ovf  ring consume / overflow clear strobes
//   i_dev_valid/data      PS2 scan-code strobe and data
//   o_bram_*, i_bram_dout BRAM port (1-cycle synchronous read)
//   o_ring_count/wr_ptr   ring occupancy and next write slot
//   o_overflow, o_dev_irq sticky drop flag, ring-not-empty interrupt
module ps2_bram_arbiter #(
   parameter int unsigned AW        = 9,
   parameter int unsigned DW        = 8,
   parameter int unsigned RING_BASE = 0,
   parameter int unsigned RING_LOG2 = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_cpu_we,
   input  logic                 i_cpu_re,
   input  logic [AW-1:0]        i_cpu_addr,
   input  logic [DW-1:0]        i_cpu_wdata,
   output logic [DW-1:0]        o_cpu_rdata,
   output logic                 o_cpu_rvalid,
   input  logic                 i_cpu_pop,
   input  logic                 i_cpu_clr_ovf,
   input  logic                 i_dev_valid,
   input  logic [DW-1:0]        i_dev_data,
   output logic                 o_bram_en,
   output logic                 o_bram_we,
   output logic [AW-1:0]        o_bram_addr,
   output logic [DW-1:0]        o_bram_din,
   input  logic [DW-1:0]        i_bram_dout,
   output logic [RING_LOG2:0]   o_ring_count,
   output logic [RING_LOG2-1:0] o_ring_wr_ptr,
   output logic                 o_overflow,
   output logic                 o_dev_irq
);

   localparam int unsigned DEPTH = 2 ** RING_LOG2;
   localparam int unsigned CW    = RING_LOG2 + 1;

   logic          r_dev_pend;
   logic [DW-1:0] r_dev_data;
   logic          r_rd_s1;
   logic          r_rd_s2;

   logic          w_cpu_strobe;
   logic          w_dev_grant;
   logic          w_ring_full;
   logic          w_dev_accept;
   logic          w_dev_drop;
   logic          w_pop;
   logic [CW-1:0] w_count_next;
   logic [AW-1:0] w_ring_addr;

   // Any CPU strobe owns the port this edge; the device only gets idle edges.
   assign w_cpu_strobe = i_cpu_we | i_cpu_re;
   assign w_dev_grant  = r_dev_pend & ~w_cpu_strobe;
   assign w_ring_full  = (o_ring_count == CW'(DEPTH));
   // Acceptance looks at the pre-edge pending bit, so a code arriving on
   // the grant edge is dropped.
   assign w_dev_accept = i_dev_valid & ~r_dev_pend & ~w_ring_full;
   assign w_dev_drop   = i_dev_valid & ~w_dev_accept;
   assign w_pop        = i_cpu_pop & (o_ring_count != '0);
   assign w_ring_addr  = AW'(RING_BASE) + AW'(o_ring_wr_ptr);

   // Occupancy: a grant and a pop on the same edge cancel.
   always_comb begin
      w_count_next = o_ring_count;
      if (w_dev_grant && !w_pop)
         w_count_next = o_ring_count + 1'b1;
      else if (!w_dev_grant && w_pop)
         w_count_next = o_ring_count - 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_cpu_rdata   <= '0;
         o_cpu_rvalid  <= 1'b0;
         o_bram_en     <= 1'b0;
         o_bram_we     <= 1'b0;
         o_bram_addr   <= '0;
         o_bram_din    <= '0;
         o_ring_count  <= '0;
         o_ring_wr_ptr <= '0;
         o_overflow    <= 1'b0;
         o_dev_irq     <= 1'b0;
         r_dev_pend    <= 1'b0;
         r_dev_data    <= '0;
         r_rd_s1       <= 1'b0;
         r_rd_s2       <= 1'b0;
      end else begin
         o_bram_en <= 1'b0;
         o_bram_we <= 1'b0;
         r_rd_s1   <= 1'b0;

         // Port grant, fixed priority.
         if (i_cpu_we) begin
            o_bram_en   <= 1'b1;
            o_bram_we   <= 1'b1;
            o_bram_addr <= i_cpu_addr;
            o_bram_din  <= i_cpu_wdata;
         end else if (i_cpu_re) begin
            o_bram_en   <= 1'b1;
            o_bram_addr <= i_cpu_addr;
            r_rd_s1     <= 1'b1;
         end else if (r_dev_pend) begin
            o_bram_en   <= 1'b1;
            o_bram_we   <= 1'b1;
            o_bram_addr <= w_ring_addr;
            o_bram_din  <= r_dev_data;
         end

         // Read pipeline: address cycle, BRAM latency, capture.
         r_rd_s2      <= r_rd_s1;
         o_cpu_rvalid <= r_rd_s2;
         if (r_rd_s2)
            o_cpu_rdata <= i_bram_dout;

         // Pending scan-code register; accept and grant are exclusive.
         if (w_dev_grant) begin
            r_dev_pend    <= 1'b0;
            o_ring_wr_ptr <= o_ring_wr_ptr + 1'b1;
         end else if (w_dev_accept) begin
            r_dev_pend <= 1'b1;
            r_dev_data <= i_dev_data;
         end

         o_ring_count <= w_count_next;
         o_dev_irq    <= (w_count_next != '0);

         // Set beats clear.
         if (w_dev_drop)
            o_overflow <= 1'b1;
         else if (i_cpu_clr_ovf)
            o_overflow <= 1'b0;
      end
   end

endmodule

// File: doc/ps2_bram_arbiter.md
Name: ps2_bram_arbiter

Overview:
Shares one single-port BRAM between the CPU bus and the PS2 receiver.
- The CPU side issues single-cycle write strobes (from the bus write-pulse logic) and read strobes to any BRAM address.
- The PS2 side pushes scan codes into a ring buffer region of the same BRAM.
- The block arbitrates port access, maintains the ring write pointer, occupancy count and overflow flag, and returns CPU read data with fixed latency.

Parameters:
AW, 9, BRAM address width
DW, 8, BRAM data width
RING_BASE, 0, first BRAM address of the scan-code ring
RING_LOG2, 4, log2 of ring depth (depth = 2^RING_LOG2 = 16)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_we  in  1  one-cycle CPU write strobe
cpu_re  in  1  one-cycle CPU read strobe
cpu_addr  in  AW  CPU address (valid with strobe)
cpu_wdata  in  DW  CPU write data (valid with cpu_we)
cpu_rdata  out  DW  CPU read data
cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
cpu_pop  in  1  one-cycle strobe: CPU consumed one ring entry
cpu_clr_ovf  in  1  one-cycle strobe: clear overflow
dev_valid  in  1  one-cycle PS2 scan-code strobe
dev_data  in  DW  scan code (valid with dev_valid)
bram_en  out  1  BRAM enable
bram_we  out  1  BRAM write enable
bram_addr  out  AW  BRAM address
bram_din  out  DW  BRAM write data
bram_dout  in  DW  BRAM read data (synchronous, 1-cycle latency)
ring_count  out  RING_LOG2+1  entries held in ring (0..2^RING_LOG2)
ring_wr_ptr  out  RING_LOG2  next ring slot to be written
overflow  out  1  sticky: a scan code was dropped
dev_irq  out  1  high while ring_count != 0

Behaviour:
Reset and output registration:
- All outputs are registered.
- Reset clears every output, pending register and pointer to 0.
- Reset mid-operation discards the pending scan code and any in-flight read (no cpu_rvalid is produced).

Arbitration, evaluated at each clk edge; exactly one grant or none, with fixed priority:
1. cpu_we
2. cpu_re
3. pending device write
- cpu_we and cpu_re in the same cycle: the write is granted and the read is dropped.
- A CPU strobe is always granted on the edge where it is sampled. CPU never waits.

CPU write grant:
- On the next cycle: bram_en=1, bram_we=1, bram_addr=cpu_addr, bram_din=cpu_wdata, for exactly 1 cycle.

CPU read grant:
- Cycle after the grant edge k: bram_en=1, bram_we=0, bram_addr=cpu_addr.
- At edge k+2: cpu_rdata is captured from bram_dout and cpu_rvalid pulses for 1 cycle.
- Read-to-rvalid latency is 2 cycles. The port is free again from edge k+1, so back-to-back reads pipeline.

Device capture:
- dev_valid sets the 1-deep pending register (dev_pend, holding data) only if dev_pend=0 and ring_count < 2^RING_LOG2.
- Otherwise the code is dropped and overflow is set.
- A dev_valid arriving on the same edge as a device grant sees dev_pend=1 and is dropped.

Device grant (dev_pend=1, no CPU strobe that edge):
- Next cycle: bram_en=1, bram_we=1, bram_addr=RING_BASE+ring_wr_ptr, bram_din=pending data.
- At the grant edge: dev_pend clears, ring_wr_ptr increments modulo 2^RING_LOG2 (wraps 15 to 0), and ring_count increments.
- Device latency: dev_valid sampled at edge k is granted at edge k+1 if no CPU strobe is present, otherwise at the first edge without one.

Ring count and pop:
- cpu_pop decrements ring_count if ring_count > 0; pop at 0 is ignored.
- Device grant and pop on the same edge leave ring_count unchanged.
- ring_count never exceeds 2^RING_LOG2.

Overflow:
- overflow is cleared only by cpu_clr_ovf or reset.
- A set condition and cpu_clr_ovf on the same edge: overflow stays 1 (set wins).

bram_en and bram_we are 0 in every cycle with no grant.

Test Plan:
1. cpu_we, addr=0x1A0, data=0x5C -> next cycle bram_en=1, bram_we=1, bram_addr=0x1A0, bram_din=0x5C for 1 cycle; nothing else granted.
2. BRAM preloaded with 0x33 at 0x042; cpu_re, addr=0x042 -> bram_en=1, bram_we=0 one cycle later; cpu_rvalid=1 with cpu_rdata=0x33 two cycles after the strobe; back-to-back reads to 0x042, 0x043 yield two rvalid pulses on consecutive cycles.
3. dev_valid (0xF0) on the same edge as cpu_we -> CPU write issued first; device write to RING_BASE+0 issued the following cycle; ring_count=1, ring_wr_ptr=1, dev_irq=1.
4. 16 scan codes with no pop -> ring_count=16, ring_wr_ptr=0 (wrapped); 17th dev_valid -> no BRAM write, overflow=1; cpu_clr_ovf -> overflow=0; cpu_pop -> ring_count=15.
5. cpu_pop coinciding with a device grant at ring_count=5 -> ring_count stays 5; cpu_pop at ring_count=0 -> remains 0.
6. Assert reset one cycle after a cpu_re strobe with dev_pend=1 -> no cpu_rvalid, no device write; all outputs 0 on the cycle after reset.
